// File: rtl/uart_rx.sv
// uart_rx: 16x oversampled UART receive engine; deframes start/data/parity/stop into one-cycle pushes.
// Optional macro UART_RX_MAJORITY_EN: decide each bit by majority of samples at ticks 6,7,8.
module uart_rx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baud_tick,
  input  logic       rx,
  input  logic [1:0] cfg_data_bits,
  input  logic       cfg_parity_en,
  input  logic       cfg_parity_even,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_parity_err,
  output logic       rx_frame_err,
  output logic       rx_break,
  output logic       rx_busy
);

  localparam logic [3:0] CNT_LAST = 4'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  localparam logic [3:0] DEC = 4'd8;
`else
  localparam logic [3:0] DEC = 4'd7;
`endif

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;

  state_t     state_q, state_n;
  logic       rx_s1, rx_s2;
  logic [3:0] cnt_q, cnt_n;
  logic [2:0] idx_q, idx_n;
  logic [2:0] last_idx;
  logic [7:0] data_q;
  logic [1:0] len_q;
  logic       par_en_q, par_even_q, pbit_q;
  logic       bit_val, at_dec, latch_cfg, push, brk, perr;

  function automatic logic parity_mismatch(input logic [7:0] d, input logic p, input logic even);
    logic x;
    x = (^d) ^ p;
    return even ? x : ~x;
  endfunction

  // Synchronizer stage: the line idles high, so reset to 1 to avoid a phantom start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic vote6_q, vote7_q;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  always_ff @(posedge clk) begin
    if (baud_tick && cnt_q == 4'd6) vote6_q <= rx_s2;
    if (baud_tick && cnt_q == 4'd7) vote7_q <= rx_s2;
  end

  assign bit_val = maj3(vote6_q, vote7_q, rx_s2);
`else
  assign bit_val = rx_s2;
`endif

  assign at_dec   = baud_tick && (cnt_q == DEC);
  assign last_idx = 3'd4 + {1'b0, len_q};
  assign perr     = par_en_q && parity_mismatch(data_q, pbit_q, par_even_q);
  assign brk      = (data_q == 8'h00) && !(par_en_q && pbit_q) && !bit_val;
  assign rx_busy  = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      idx_q   <= idx_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    cnt_n     = cnt_q;
    idx_n     = idx_q;
    latch_cfg = 1'b0;
    push      = 1'b0;
    if (baud_tick) begin
      cnt_n = cnt_q + 4'd1;
      case (state_q)
        IDLE: begin
          cnt_n = 4'd0;
          if (!rx_s2) state_n = START;
        end
        START: begin
          if (cnt_q == DEC) begin
            if (bit_val) begin
              state_n = IDLE;
              cnt_n   = 4'd0;
            end else begin
              latch_cfg = 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            state_n = DATA;
            idx_n   = 3'd0;
          end
        end
        DATA: begin
          if (cnt_q == CNT_LAST) begin
            if (idx_q == last_idx) state_n = par_en_q ? PARITY : STOP;
            else                   idx_n   = idx_q + 3'd1;
          end
        end
        PARITY: begin
          if (cnt_q == CNT_LAST) state_n = STOP;
        end
        STOP: begin
          // Leave mid-stop so the next start edge is caught without losing half a bit.
          if (cnt_q == DEC) begin
            push    = 1'b1;
            cnt_n   = 4'd0;
            state_n = brk ? BRK_WAIT : IDLE;
          end
        end
        BRK_WAIT: begin
          cnt_n = 4'd0;
          if (rx_s2) state_n = IDLE;
        end
        default: begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end
      endcase
    end
  end

  // Frame assembly stage: config is frozen at the start-bit decision.
  always_ff @(posedge clk) begin
    if (latch_cfg) begin
      data_q     <= 8'h00;
      len_q      <= cfg_data_bits;
      par_en_q   <= cfg_parity_en;
      par_even_q <= cfg_parity_even;
    end
    if (at_dec && state_q == DATA)   data_q[idx_q] <= bit_val;
    if (at_dec && state_q == PARITY) pbit_q        <= bit_val;
  end

  // Output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid      <= 1'b0;
      rx_data       <= 8'h00;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      rx_break      <= 1'b0;
    end else begin
      rx_valid <= push;
      if (push) begin
        rx_data       <= data_q;
        rx_parity_err <= perr;
        rx_frame_err  <= ~bit_val;
        rx_break      <= brk;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames for uart_rx with a queue-based scoreboard and an independent push monitor.
`timescale 1ns/1ps
module tb_uart_rx;

`ifdef UART_RX_MAJORITY_EN
  localparam int DEC = 8;
  localparam logic [7:0] GLITCH_EXP = 8'hFF;
`else
  localparam int DEC = 7;
  localparam logic [7:0] GLITCH_EXP = 8'hFE;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick = 1'b0;
  logic       rx;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_even;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_parity_err;
  logic       rx_frame_err;
  logic       rx_break;
  logic       rx_busy;

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       fe;
    logic       bk;
    int         cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   div     = 0;

  uart_rx dut (
    .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx(rx),
    .cfg_data_bits(cfg_data_bits), .cfg_parity_en(cfg_parity_en),
    .cfg_parity_even(cfg_parity_even), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
    .rx_break(rx_break), .rx_busy(rx_busy)
  );

  always #5 clk = ~clk;

  // Tick every 4 clocks, changed on the falling edge so it is stable at the rising edge.
  always @(negedge clk) begin
    baud_tick = (div == 0);
    div = (div == 3) ? 0 : div + 1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Drive one oversample slot: the value is seen by the DUT at the next tick edge.
  task automatic slot(input logic v);
    rx = v;
    do @(posedge clk); while (baud_tick !== 1'b1);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) slot(1'b1);
  endtask

  task automatic send_bit(input logic v, input int glitch_slot);
    for (int s = 0; s < 16; s++) slot((s == glitch_slot) ? ~v : v);
  endtask

  task automatic set_cfg(input logic [1:0] bits, input logic pen, input logic peven);
    cfg_data_bits   = bits;
    cfg_parity_en   = pen;
    cfg_parity_even = peven;
  endtask

  // stop_mode: 0 = high stop, 1 = low only through the decision slot, 2 = low and held low.
  task automatic send_frame(input logic [7:0] d, input int nb, input logic pen, input logic pbit,
                            input int stop_mode, input int glitch_bit,
                            input logic [7:0] ed, input logic epe, input logic efe, input logic ebk);
    exp_t e;
    logic v;
    send_bit(1'b0, -1);
    for (int i = 0; i < nb; i++) send_bit(d[i], (i == glitch_bit) ? 8 : -1);
    if (pen) send_bit(pbit, -1);
    for (int s = 0; s < 16; s++) begin
      if (stop_mode == 0)      v = 1'b1;
      else if (stop_mode == 2) v = 1'b0;
      else                     v = (s <= DEC + 1) ? 1'b0 : 1'b1;
      slot(v);
      if (s == DEC + 1) begin
        e.d = ed; e.pe = epe; e.fe = efe; e.bk = ebk; e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  // Monitor: every push is popped against the scoreboard and must last exactly one clock.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_valid === 1'b1) begin
        n_tests++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_push: got data=%02h pe=%b fe=%b bk=%b, expected no push",
                   rx_data, rx_parity_err, rx_frame_err, rx_break);
        end else begin
          mon_e = q.pop_front();
          if (rx_data !== mon_e.d || rx_parity_err !== mon_e.pe || rx_frame_err !== mon_e.fe ||
              rx_break !== mon_e.bk || cyc != mon_e.cyc) begin
            n_fail++;
            $display("FAIL push: got data=%02h pe=%b fe=%b bk=%b cyc=%0d, expected data=%02h pe=%b fe=%b bk=%b cyc=%0d",
                     rx_data, rx_parity_err, rx_frame_err, rx_break, cyc,
                     mon_e.d, mon_e.pe, mon_e.fe, mon_e.bk, mon_e.cyc);
          end
        end
        @(negedge clk);
        n_tests++;
        if (rx_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL valid_width: got rx_valid=%b on second clock, expected 0", rx_valid);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    set_cfg(2'd3, 1'b0, 1'b0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    chk("reset_state", 32'({rx_valid, rx_busy, rx_parity_err, rx_frame_err, rx_break, rx_data}), 32'h0);
    idle(32);

    // 8N1 0x55
    send_frame(8'h55, 8, 1'b0, 1'b0, 0, -1, 8'h55, 1'b0, 1'b0, 1'b0);
    idle(32);

    // 7E1 0x41: two ones, so parity bit 1 is wrong for even, 0 is right
    set_cfg(2'd2, 1'b1, 1'b1);
    send_frame(8'h41, 7, 1'b1, 1'b1, 0, -1, 8'h41, 1'b1, 1'b0, 1'b0);
    idle(16);
    send_frame(8'h41, 7, 1'b1, 1'b0, 0, -1, 8'h41, 1'b0, 1'b0, 1'b0);
    idle(16);
    // 7O1: parity bit 1 is right for odd
    set_cfg(2'd2, 1'b1, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 0, -1, 8'h41, 1'b0, 1'b0, 1'b0);
    idle(16);

    // 5N1: upper bits must read zero
    set_cfg(2'd0, 1'b0, 1'b0);
    send_frame(8'h1A, 5, 1'b0, 1'b0, 0, -1, 8'h1A, 1'b0, 1'b0, 1'b0);
    idle(16);

    // 4-tick low glitch in idle: false start, no push
    set_cfg(2'd3, 1'b0, 1'b0);
    slot(1'b0);
    chk("glitch_busy_high", 32'(rx_busy), 32'h1);
    slot(1'b0); slot(1'b0); slot(1'b0);
    idle(12);
    chk("glitch_busy_low", 32'(rx_busy), 32'h0);
    idle(16);

    // Break: 0x00 with stop low, line held low 40 bit times
    send_frame(8'h00, 8, 1'b0, 1'b0, 2, -1, 8'h00, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 40 * 16; i++) slot(1'b0);
    chk("break_busy", 32'(rx_busy), 32'h1);
    idle(2);
    chk("break_release", 32'(rx_busy), 32'h0);
    idle(30);
    send_frame(8'hA5, 8, 1'b0, 1'b0, 0, -1, 8'hA5, 1'b0, 1'b0, 1'b0);
    idle(16);

    // 0xFF with a low stop bit, next frame back to back
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1, -1, 8'hFF, 1'b0, 1'b1, 1'b0);
    send_frame(8'h3C, 8, 1'b0, 1'b0, 0, -1, 8'h3C, 1'b0, 1'b0, 1'b0);
    idle(16);

    // 1-tick low glitch on data bit 0 at its decision sample
    send_frame(8'hFF, 8, 1'b0, 1'b0, 0, 0, GLITCH_EXP, 1'b0, 1'b0, 1'b0);
    idle(16);

    // Reset during bit 3 of 0xC3: abort with no push
    send_bit(1'b0, -1);
    send_bit(1'b1, -1); send_bit(1'b1, -1); send_bit(1'b0, -1);
    for (int s = 0; s < 5; s++) slot(1'b0);
    chk("busy_before_rst", 32'(rx_busy), 32'h1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("midframe_rst", 32'({rx_valid, rx_busy, rx_parity_err, rx_frame_err, rx_break, rx_data}), 32'h0);
    idle(48);
    send_frame(8'h96, 8, 1'b0, 1'b0, 0, -1, 8'h96, 1'b0, 1'b0, 1'b0);
    idle(16);

    chk("scoreboard_drained", 32'(q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
